// File: rtl/mux1_arbiter_if.sv
// Request/grant/result bundle between the two clients and the MUX1 arbiter.
interface mux1_arbiter_if;
  logic       req0;
  logic [6:0] op0;
  logic       req1;
  logic [6:0] op1;
  logic       gnt0;
  logic       gnt1;
  logic       res_valid;
  logic       res;
  logic       res_bar;
  logic       res_id;
  logic       busy;

  // Client side: raises requests and operands, watches grants and results.
  modport master (
    output req0, op0, req1, op1,
    input  gnt0, gnt1, res_valid, res, res_bar, res_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req0, op0, req1, op1,
    output gnt0, gnt1, res_valid, res, res_bar, res_id, busy
  );
endinterface

// File: rtl/mux1_arbiter.sv
// Round-robin arbiter sharing one MUX1 select unit between two requesters.
//
// state | meaning
// IDLE  | waiting for a request; captures the winner's operands on the edge
// EVAL  | MUX1 evaluates op_reg; result registered on the edge
// RESP  | result visible; returns to IDLE (requests ignored)
module mux1_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mux1_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t     state;
  logic       ptr;
  logic [6:0] op_reg;
  logic       id_reg;
  logic       mux_out;
  logic       mux_out_bar;
  logic       winner;

  // MUX1: Sel=1 gives XNOR of A/B/C, Sel=0 gives (D0&D1)|D2; fed only from op_reg.
  always_comb begin
    if (op_reg[6]) mux_out = ~(op_reg[5] ^ op_reg[4] ^ op_reg[3]);
    else           mux_out = (op_reg[0] & op_reg[1]) | op_reg[2];
    mux_out_bar = ~mux_out;
  end

  // Winner: a lone requester always wins; under contention ptr decides.
  always_comb begin
    winner = (bus.req0 && bus.req1) ? ptr : bus.req1;
  end

  // Sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      op_reg        <= 7'd0;
      id_reg        <= 1'b0;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res       <= 1'b0;
      bus.res_bar   <= 1'b1;
      bus.res_id    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            op_reg   <= winner ? bus.op1 : bus.op0;
            id_reg   <= winner;
            bus.gnt0 <= ~winner;
            bus.gnt1 <= winner;
            bus.busy <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          bus.res       <= mux_out;
          bus.res_bar   <= mux_out_bar;
          bus.res_id    <= id_reg;
          bus.res_valid <= 1'b1;
          ptr           <= ~id_reg;
          state         <= RESP;
        end
        RESP: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
